addsub_sequencer: RTL and testbench
===================================

Name: addsub_sequencer

Overview:
- Upstream controller for the 8-bit carry-lookahead add/subtract stage.
- Accepts ALU requests over a valid/ready handshake and presents registered operands to the adder, using c_in as the subtract select.
- Waits for the adder's ready, captures the sum and flags, and returns a response over a second valid/ready handshake.
- Sits between instruction decode and the register-file writeback.

Parameters:
- TIMEOUT, 16, max cycles in EXEC waiting for add_ready before aborting with error (range 2..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_op  in  3  0=ADD 1=SUB 2=CMP 3=INC 4=DEC, 5-7 illegal
- req_a  in  8  operand A
- req_b  in  8  operand B (ignored for INC/DEC)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_result  out  8  result register
- resp_flags  out  4  {Z,N,C,V}
- resp_err  out  1  illegal op or adder timeout
- add_en  out  1  adder enable
- add_cin  out  1  adder carry-in / subtract select (adder internally XORs B with cin)
- add_a  out  8  adder operand A
- add_b  out  8  adder operand B, before the adder's inversion
- add_sum  in  8  adder output
- add_cout  in  1  adder carry-out
- add_ready  in  1  adder result valid

Behaviour:
- Reset values: state=IDLE; all outputs 0, except req_ready=1 (follows IDLE); result, flags and err registers 0; timeout counter 0.
- Reset overrides everything, including mid-EXEC and mid-RESP; any in-flight request is dropped with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - On req_valid&&req_ready, latch op, a and b.
  - Legal op -> EXEC. Illegal op -> RESP with err=1; result and flags unchanged.
- Operand mapping, registered on accept and held stable through EXEC:
  - ADD: a, b, cin=0.
  - SUB and CMP: a, b, cin=1.
  - INC: a, 0xFF, cin=1 (computes a+0x00+1).
  - DEC: a, 0xFF, cin=0 (computes a+0xFF).
- EXEC:
  - add_en=1 and the timeout counter increments each cycle.
  - If add_ready=1 in a cycle: capture add_sum/add_cout at that edge -> RESP.
  - Else if counter reaches TIMEOUT-1: -> RESP with err=1; result and flags unchanged.
  - add_en is 0 in every other state.
- Capture rules:
  - Z = (sum==0).
  - N = sum[7].
  - C = add_cout raw; for SUB/CMP, C=1 means no borrow.
  - V = (a[7]==d[7]) && (sum[7]!=a[7]), where d = add_b XOR {8{cin}}.
  - CMP updates flags only; the result register keeps its prior value.
  - err is cleared on every successful capture.
- RESP:
  - resp_valid=1, with result/flags/err stable while resp_ready=0.
  - On resp_ready=1 -> IDLE; resp_valid drops the next cycle.
- Latency, adder ready in its first EXEC cycle:
  - Accept at edge 0, EXEC during cycle 1, resp_valid during cycle 2.
  - With resp_ready held high, the next accept is possible at cycle 3, giving throughput of 1 op per 3 cycles.
- No new request is accepted in EXEC or RESP, so requests never overlap.
- add_ready seen outside EXEC is ignored.
- Width rule: all arithmetic is 8-bit modulo 256; carry is visible only in C.

Decomposition:
- Shared package holds:
  - op encodings OP_ADD..OP_DEC;
  - state encodings;
  - flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
- No sub-module. The flag computation is a small combinational function in the same package, reusable by the future logic unit.

Test Plan:
- ADD 0x7F,0x01 with instant-ready adder model -> resp_result=0x80, flags Z0 N1 C0 V1, resp_valid in the 2nd cycle after accept.
- SUB 0x05,0x05 -> result 0x00, Z1 N0 C1 V0. Then CMP 0x03,0x05 -> flags Z0 N1 C0 V0, result stays 0x00.
- INC 0xFF -> 0x00, Z1 C1. DEC 0x00 -> 0xFF, N1 C0. DEC 0x80 -> 0x7F, V1.
- Adder model with add_ready delayed 3 cycles, and resp_ready held low 5 cycles -> add_en high exactly 4 cycles, response held stable, req_ready low until handshake completes.
- add_ready stuck 0, TIMEOUT=16 -> add_en high 16 cycles, resp_err=1, prior result/flags retained. Next legal ADD clears err.
- req_op=6 -> resp_err=1 one cycle after accept, add_en never asserted. Reset asserted during EXEC -> no response, all outputs at reset values, req_ready=1 next cycle.

Source files
------------

// File: rtl/addsub_sequencer_pkg.sv
// Shared definitions for the add/subtract sequencer: op codes, FSM states,
// flag bit positions and the flag computation used at result capture.
package addsub_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_CMP = 3'd2,
    OP_INC = 3'd3,
    OP_DEC = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Codes 5..7 are reserved and answered with an error response.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= 3'(OP_DEC));
  endfunction

  // Flags for an adder computing a + (b ^ {8{cin}}) + cin. V compares the
  // sign of A with the sign of the operand the adder actually saw.
  function automatic logic [3:0] calc_flags(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic       cin,
                                            input logic [7:0] sum,
                                            input logic       cout);
    logic [7:0] d;
    logic [3:0] f;
    d         = b ^ {8{cin}};
    f         = '0;
    f[FLAG_Z] = (sum == 8'h00);
    f[FLAG_N] = sum[7];
    f[FLAG_C] = cout;
    f[FLAG_V] = (a[7] == d[7]) && (sum[7] != a[7]);
    return f;
  endfunction

endpackage

// File: rtl/addsub_sequencer.sv
// Request/response sequencer in front of the 8-bit add/subtract stage.
// Latches a request, holds mapped operands on the adder until it reports
// ready (or a timeout expires), then presents the captured result.
module addsub_sequencer
  import addsub_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_result,
  output logic [3:0] resp_flags,
  output logic       resp_err,
  output logic       add_en,
  output logic       add_cin,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  input  logic       add_ready
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [2:0] op_q;
  logic [7:0] add_a_q;
  logic [7:0] add_b_q;
  logic       add_cin_q;
  logic [7:0] result_q;
  logic [3:0] flags_q;
  logic       err_q;
  logic [7:0] cnt_q;

  logic [7:0] map_b_d;
  logic       map_cin_d;
  logic [3:0] flags_d;
  logic [7:0] result_d;

  // Operand mapping of the incoming request and the capture values from the adder.
  always_comb begin
    map_b_d   = req_b;
    map_cin_d = 1'b0;
    case (req_op)
      3'(OP_SUB), 3'(OP_CMP): map_cin_d = 1'b1;
      3'(OP_INC): begin
        map_b_d   = 8'hFF;
        map_cin_d = 1'b1;
      end
      3'(OP_DEC): begin
        map_b_d   = 8'hFF;
        map_cin_d = 1'b0;
      end
      default: ;
    endcase
    flags_d  = calc_flags(add_a_q, add_b_q, add_cin_q, add_sum, add_cout);
    // CMP only updates the flags; the result register keeps its value.
    result_d = (op_q == 3'(OP_CMP)) ? result_q : add_sum;
  end

  // Control FSM with all datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q <= req_op;
            if (is_legal_op(req_op)) begin
              add_a_q   <= req_a;
              add_b_q   <= map_b_d;
              add_cin_q <= map_cin_d;
              cnt_q     <= '0;
              state_q   <= ST_EXEC;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          if (add_ready) begin
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_RESP;
          end else if (cnt_q == TIMEOUT_LAST) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake and enable outputs decode directly from the state register.
  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign add_en      = (state_q == ST_EXEC);
  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign add_cin     = add_cin_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Self-checking bench for addsub_sequencer with a behavioural adder model
// and an arithmetic reference model of the expected result and flags.
module tb_addsub_sequencer;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_result;
  logic [3:0] resp_flags;
  logic       resp_err;
  logic       add_en;
  logic       add_cin;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       add_ready;

  int checks   = 0;
  int failures = 0;

  // Adder model controls
  int ready_delay = 0;
  bit ready_stuck = 0;
  bit ready_force = 0;
  int en_run      = 0;
  int en_total    = 0;
  int acc_cnt     = 0;
  int rsp_cnt     = 0;

  // Expected architectural state
  logic [7:0] exp_res = 8'h00;
  logic [3:0] exp_flg = 4'h0;

  addsub_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
    .add_en(add_en), .add_cin(add_cin), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_cout(add_cout), .add_ready(add_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder: inverts B with cin and adds cin.
  logic [8:0] add_full;
  assign add_full  = {1'b0, add_a} + {1'b0, add_b ^ {8{add_cin}}} + {8'd0, add_cin};
  assign add_sum   = add_full[7:0];
  assign add_cout  = add_full[8];
  assign add_ready = ready_force | (add_en & ~ready_stuck & (en_run >= ready_delay));

  always @(posedge clk) begin
    en_run <= add_en ? en_run + 1 : 0;
    if (add_en) en_total <= en_total + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    if (resp_valid && resp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model using plain integer arithmetic on unsigned/signed values.
  function automatic void ref_model(input logic [2:0] op, input logic [7:0] a,
                                    input logic [7:0] b, output logic [7:0] res,
                                    output logic [3:0] fl);
    int ua, ub, sa, sb, r, s;
    logic c;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'd0: begin r = ua + ub; c = (r > 255); s = sa + sb; end
      3'd1, 3'd2: begin r = ua - ub; c = (ua >= ub); s = sa - sb; end
      3'd3: begin r = ua + 1; c = (ua == 255); s = sa + 1; end
      default: begin r = ua - 1; c = (ua != 0); s = sa - 1; end
    endcase
    res = r[7:0];
    fl  = {(res == 8'h00), res[7], c, ((s > 127) || (s < -128))};
  endfunction

  task automatic model_apply(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [3:0] f;
    ref_model(op, a, b, r, f);
    exp_flg = f;
    if (op != 3'd2) exp_res = r;
  endtask

  // Drives one request and waits for its response; leaves resp_ready low.
  task automatic send_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output bit ok);
    int w;
    w   = 0;
    ok  = 1;
    lat = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      ok = 0;
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    lat       = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) ok = 0;
    $display("txn op=%0d a=%h b=%h lat=%0d res=%h flags=%b err=%b",
             op, a, b, lat, resp_result, resp_flags, resp_err);
  endtask

  task automatic complete_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || add_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: rr=%b rv=%b en=%b required 1 0 0", req_ready, resp_valid, add_en);
    end
    checks++;
    if ({add_a, add_b, add_cin} !== 17'd0) begin
      failures++;
      $display("FAIL reset_operands: a=%h b=%h cin=%b required 0", add_a, add_b, add_cin);
    end
    checks++;
    if ({resp_result, resp_flags, resp_err} !== 13'd0) begin
      failures++;
      $display("FAIL reset_resp: res=%h fl=%b err=%b required 0", resp_result, resp_flags, resp_err);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0] ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [7:0] as  [6] = '{8'h7F, 8'h05, 8'h03, 8'hFF, 8'h00, 8'h80};
    logic [7:0] bs  [6] = '{8'h01, 8'h05, 8'h05, 8'h12, 8'h34, 8'h56};
    logic [7:0] rs  [6] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h7F};
    logic [3:0] fs  [6] = '{4'b0101, 4'b1010, 4'b0100, 4'b1010, 4'b0100, 4'b0011};
    int lat, e0;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      e0 = en_total;
      send_req(ops[i], as[i], bs[i], lat, ok);
      model_apply(ops[i], as[i], bs[i]);
      checks++;
      if (!ok || lat != 2 || en_total - e0 != 1) begin
        failures++;
        $display("FAIL directed_timing[%0d]: ok=%0d lat=%0d en=%0d required 1 2 1", i, ok, lat, en_total - e0);
      end
      checks++;
      if (resp_result !== rs[i] || resp_flags !== fs[i] || resp_err !== 1'b0) begin
        failures++;
        $display("FAIL directed_value[%0d]: res=%h fl=%b err=%b required %h %b 0",
                 i, resp_result, resp_flags, resp_err, rs[i], fs[i]);
      end
      complete_resp();
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL directed_release[%0d]: rv=%b rr=%b required 0 1", i, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [7:0] a, b;
    int lat, hold;
    bit ok;
    for (int i = 0; i < 30; i++) begin
      op          = 3'($urandom_range(0, 4));
      a           = 8'($urandom);
      b           = 8'($urandom);
      hold        = $urandom_range(0, 2);
      ready_delay = $urandom_range(0, 2);
      send_req(op, a, b, lat, ok);
      model_apply(op, a, b);
      checks++;
      if (!ok || lat != 2 + ready_delay) begin
        failures++;
        $display("FAIL random_latency[%0d]: ok=%0d lat=%0d required %0d", i, ok, lat, 2 + ready_delay);
      end
      checks++;
      if (resp_result !== exp_res || resp_flags !== exp_flg || resp_err !== 1'b0) begin
        failures++;
        $display("FAIL random_value[%0d] op=%0d a=%h b=%h: res=%h fl=%b err=%b required %h %b 0",
                 i, op, a, b, resp_result, resp_flags, resp_err, exp_res, exp_flg);
      end
      repeat (hold) @(negedge clk);
      complete_resp();
    end
    ready_delay = 0;
  endtask

  task automatic test_slow_adder();
    logic [7:0] a, b;
    int lat, e0;
    bit ok;
    a = 8'($urandom);
    b = 8'($urandom);
    ready_delay = 3;
    e0 = en_total;
    send_req(3'd1, a, b, lat, ok);
    model_apply(3'd1, a, b);
    checks++;
    if (!ok || lat != 5 || en_total - e0 != 4) begin
      failures++;
      $display("FAIL slow_timing: ok=%0d lat=%0d en=%0d required 1 5 4", ok, lat, en_total - e0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_result !== exp_res ||
          resp_flags !== exp_flg || resp_err !== 1'b0) begin
        failures++;
        $display("FAIL slow_hold[%0d]: rv=%b rr=%b res=%h fl=%b err=%b required 1 0 %h %b 0",
                 i, resp_valid, req_ready, resp_result, resp_flags, resp_err, exp_res, exp_flg);
      end
      @(negedge clk);
    end
    complete_resp();
    ready_delay = 0;
  endtask

  task automatic test_timeout();
    logic [7:0] a, b;
    int lat, e0;
    bit ok;
    ready_stuck = 1;
    e0 = en_total;
    send_req(3'd0, 8'h11, 8'h22, lat, ok);
    checks++;
    if (!ok || lat != 17 || en_total - e0 != 16) begin
      failures++;
      $display("FAIL timeout_timing: ok=%0d lat=%0d en=%0d required 1 17 16", ok, lat, en_total - e0);
    end
    checks++;
    if (resp_err !== 1'b1 || resp_result !== exp_res || resp_flags !== exp_flg) begin
      failures++;
      $display("FAIL timeout_value: err=%b res=%h fl=%b required 1 %h %b", resp_err, resp_result, resp_flags, exp_res, exp_flg);
    end
    complete_resp();
    ready_stuck = 0;
    a = 8'($urandom);
    b = 8'($urandom);
    send_req(3'd0, a, b, lat, ok);
    model_apply(3'd0, a, b);
    checks++;
    if (!ok || resp_err !== 1'b0 || resp_result !== exp_res || resp_flags !== exp_flg) begin
      failures++;
      $display("FAIL timeout_recover: err=%b res=%h fl=%b required 0 %h %b", resp_err, resp_result, resp_flags, exp_res, exp_flg);
    end
    complete_resp();
  endtask

  task automatic test_illegal();
    logic [2:0] ill [2] = '{3'd6, 3'd7};
    int lat, e0;
    bit ok;
    ready_force = 1;
    for (int i = 0; i < 2; i++) begin
      e0 = en_total;
      send_req(ill[i], 8'($urandom), 8'($urandom), lat, ok);
      checks++;
      if (!ok || lat != 1 || en_total - e0 != 0) begin
        failures++;
        $display("FAIL illegal_timing[%0d]: ok=%0d lat=%0d en=%0d required 1 1 0", i, ok, lat, en_total - e0);
      end
      checks++;
      if (resp_err !== 1'b1 || resp_result !== exp_res || resp_flags !== exp_flg) begin
        failures++;
        $display("FAIL illegal_value[%0d]: err=%b res=%h fl=%b required 1 %h %b", i, resp_err, resp_result, resp_flags, exp_res, exp_flg);
      end
      complete_resp();
    end
    ready_force = 0;
  endtask

  task automatic test_reset_exec();
    int seen;
    int w;
    ready_stuck = 1;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1;
    req_op    = 3'd1;
    req_a     = 8'h5A;
    req_b     = 8'hA5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (add_en !== 1'b1) begin
      failures++;
      $display("FAIL rst_exec_pre: add_en=%b required 1", add_en);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || add_en !== 1'b0 ||
        {add_a, add_b, add_cin, resp_result, resp_flags, resp_err} !== 30'd0) begin
      failures++;
      $display("FAIL rst_exec_outputs: rr=%b rv=%b en=%b a=%h b=%h cin=%b res=%h fl=%b err=%b required reset values",
               req_ready, resp_valid, add_en, add_a, add_b, add_cin, resp_result, resp_flags, resp_err);
    end
    reset = 1'b0;
    ready_stuck = 0;
    exp_res = 8'h00;
    exp_flg = 4'h0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid || !req_ready) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_exec_quiet: busy/response cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    int a0, r0;
    a = 8'($urandom);
    b = 8'($urandom);
    a0 = acc_cnt;
    r0 = rsp_cnt;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_op     = 3'd0;
    req_a      = a;
    req_b      = b;
    repeat (30) @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("txn b2b op=0 a=%h b=%h accepts=%0d responses=%0d res=%h flags=%b",
             a, b, acc_cnt - a0, rsp_cnt - r0, resp_result, resp_flags);
    model_apply(3'd0, a, b);
    checks++;
    if (acc_cnt - a0 != 10 || rsp_cnt - r0 != 10) begin
      failures++;
      $display("FAIL b2b_throughput: accepts=%0d responses=%0d required 10 10", acc_cnt - a0, rsp_cnt - r0);
    end
    checks++;
    if (resp_result !== exp_res || resp_flags !== exp_flg || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_value: res=%h fl=%b err=%b required %h %b 0", resp_result, resp_flags, resp_err, exp_res, exp_flg);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_a      = 8'h00;
    req_b      = 8'h00;
    resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_slow_adder();
    test_timeout();
    test_illegal();
    test_reset_exec();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
